// File: rtl/axil_decoder.sv
// axil_decoder: AXI4-Lite 1-to-SLAVES address decoder, unmapped addresses answered locally with DECERR.
module axil_decoder #(
  parameter int ADDR_W       = 16,
  parameter int SLAVES       = 4,
  parameter int SLAVE_ADDR_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_W-1:0]       s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [31:0]             s_wdata,
  input  logic [3:0]              s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_W-1:0]       s_araddr,
  input  logic [2:0]              s_arprot,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [31:0]             s_rdata,
  output logic [1:0]              s_rresp,
  output logic [SLAVES-1:0]       m_awvalid,
  input  logic [SLAVES-1:0]       m_awready,
  output logic [SLAVE_ADDR_W-1:0] m_awaddr,
  output logic [2:0]              m_awprot,
  output logic [SLAVES-1:0]       m_wvalid,
  input  logic [SLAVES-1:0]       m_wready,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wstrb,
  input  logic [SLAVES-1:0]       m_bvalid,
  output logic [SLAVES-1:0]       m_bready,
  input  logic [2*SLAVES-1:0]     m_bresp,
  output logic [SLAVES-1:0]       m_arvalid,
  input  logic [SLAVES-1:0]       m_arready,
  output logic [SLAVE_ADDR_W-1:0] m_araddr,
  output logic [2:0]              m_arprot,
  input  logic [SLAVES-1:0]       m_rvalid,
  output logic [SLAVES-1:0]       m_rready,
  input  logic [32*SLAVES-1:0]    m_rdata,
  input  logic [2*SLAVES-1:0]     m_rresp
);
  localparam int IDX_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  typedef enum logic [2:0] {W_IDLE, W_ISSUE, W_ERR, W_WAIT, W_RESP} wst_t;
  typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_ERR, R_WAIT, R_RESP} rst_t;
  function automatic logic hit_f(input logic [ADDR_W-1:0] a);
    return ({1'b0, a[SLAVE_ADDR_W +: IDX_W]} < (IDX_W+1)'(SLAVES)) &&
           ((a >> (SLAVE_ADDR_W + IDX_W)) == '0);
  endfunction
  // Keeps the upstream readies low until the first clock after reset release.
  logic rdy_en;
  wst_t ws, ws_n;
  rst_t rs, rs_n;
  logic aw_held, w_held, awv, wv, whit, aw_hs, w_hs, w_go, w_hit_n, aw_done, w_done;
  logic [IDX_W-1:0] widx, ridx;
  logic [SLAVE_ADDR_W-1:0] awaddr_q, araddr_q;
  logic [2:0] awprot_q, arprot_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;
  logic [1:0] bresp_q, rresp_q;
  logic [SLAVES-1:0] sel_w, sel_r;
  logic arv, ar_hs;
  assign aw_hs   = s_awvalid && s_awready;
  assign w_hs    = s_wvalid && s_wready;
  assign ar_hs   = s_arvalid && s_arready;
  assign w_hit_n = aw_hs ? hit_f(s_awaddr) : whit;
  assign w_go    = (ws == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign aw_done = !awv || m_awready[widx];
  assign w_done  = !wv || m_wready[widx];
  assign sel_w   = SLAVES'(1) << widx;
  assign sel_r   = SLAVES'(1) << ridx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en <= 1'b0;
      ws     <= W_IDLE;
      rs     <= R_IDLE;
    end else begin
      rdy_en <= 1'b1;
      ws     <= ws_n;
      rs     <= rs_n;
    end
  end
  always_comb begin
    ws_n = ws;
    case (ws)
      W_IDLE:  if (w_go) ws_n = w_hit_n ? W_ISSUE : W_ERR;
      W_ISSUE: if (aw_done && w_done) ws_n = W_WAIT;
      W_WAIT:  if (m_bvalid[widx]) ws_n = W_RESP;
      W_ERR:   ws_n = W_RESP;
      W_RESP:  if (s_bready) ws_n = W_IDLE;
      default: ws_n = W_IDLE;
    endcase
  end
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  if (ar_hs) rs_n = hit_f(s_araddr) ? R_ISSUE : R_ERR;
      R_ISSUE: if (m_arready[ridx]) rs_n = R_WAIT;
      R_WAIT:  if (m_rvalid[ridx]) rs_n = R_RESP;
      R_ERR:   rs_n = R_RESP;
      R_RESP:  if (s_rready) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end
  always_comb begin
    s_awready = rdy_en && (ws == W_IDLE) && !aw_held;
    s_wready  = rdy_en && (ws == W_IDLE) && !w_held;
    s_bvalid  = ws == W_RESP;
    s_bresp   = bresp_q;
    m_awvalid = awv ? sel_w : '0;
    m_wvalid  = wv ? sel_w : '0;
    m_bready  = (ws == W_WAIT) ? sel_w : '0;
    m_awaddr  = awaddr_q;
    m_awprot  = awprot_q;
    m_wdata   = wdata_q;
    m_wstrb   = wstrb_q;
    s_arready = rdy_en && (rs == R_IDLE);
    s_rvalid  = rs == R_RESP;
    s_rdata   = rdata_q;
    s_rresp   = rresp_q;
    m_arvalid = arv ? sel_r : '0;
    m_rready  = (rs == R_WAIT) ? sel_r : '0;
    m_araddr  = araddr_q;
    m_arprot  = arprot_q;
  end
  // AW and W are latched independently; the transaction launches once both are present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awv      <= 1'b0;
      wv       <= 1'b0;
      whit     <= 1'b0;
      widx     <= '0;
      awaddr_q <= '0;
      awprot_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_awaddr[SLAVE_ADDR_W-1:0];
        awprot_q <= s_awprot;
        widx     <= s_awaddr[SLAVE_ADDR_W +: IDX_W];
        whit     <= hit_f(s_awaddr);
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (w_go) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        awv     <= w_hit_n;
        wv      <= w_hit_n;
      end else begin
        if (awv && m_awready[widx]) awv <= 1'b0;
        if (wv && m_wready[widx]) wv <= 1'b0;
      end
      if (ws == W_WAIT && m_bvalid[widx]) bresp_q <= m_bresp[{widx, 1'b0} +: 2];
      if (ws == W_ERR) bresp_q <= 2'b11;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arv      <= 1'b0;
      ridx     <= '0;
      araddr_q <= '0;
      arprot_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      if (ar_hs) begin
        arv      <= hit_f(s_araddr);
        ridx     <= s_araddr[SLAVE_ADDR_W +: IDX_W];
        araddr_q <= s_araddr[SLAVE_ADDR_W-1:0];
        arprot_q <= s_arprot;
      end else if (arv && m_arready[ridx]) begin
        arv <= 1'b0;
      end
      if (rs == R_WAIT && m_rvalid[ridx]) begin
        rdata_q <= m_rdata[{ridx, 5'b0} +: 32];
        rresp_q <= m_rresp[{ridx, 1'b0} +: 2];
      end
      if (rs == R_ERR) begin
        rdata_q <= '0;
        rresp_q <= 2'b11;
      end
    end
  end
endmodule

// File: tb/tb_axil_decoder.sv
// tb_axil_decoder: directed checks of axil_decoder against four stub slaves with programmable ready delay.
module tb_axil_decoder;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [15:0] s_awaddr, s_araddr;
  logic [2:0] s_awprot, s_arprot;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [5:0] m_awaddr, m_araddr;
  logic [2:0] m_awprot, m_arprot;
  logic [31:0] m_wdata;
  logic [3:0] m_wstrb;
  logic [2*N-1:0] m_bresp, m_rresp;
  logic [32*N-1:0] m_rdata;
  axil_decoder #(.ADDR_W(16), .SLAVES(N), .SLAVE_ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );
  int dly[N];
  logic [N-1:0] bhold;
  logic [31:0] rd_cfg[N];
  logic [1:0] bresp_cfg[N], rresp_cfg[N];
  int awc[N], wc[N], arc[N], aw_n[N], w_n[N], vcyc[N], arcyc;
  logic [N-1:0] aw_got, w_got, bv, rv;
  logic [5:0] l_awaddr[N], l_araddr[N];
  logic [2:0] l_awprot[N];
  logic [31:0] l_wdata[N];
  logic [3:0] l_wstrb[N];
  int n_vec = 0, n_err = 0;
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    m_arready = '0;
    m_bresp   = '0;
    m_rresp   = '0;
    m_rdata   = '0;
    for (int i = 0; i < N; i++) begin
      m_awready[i]       = m_awvalid[i] && awc[i] >= dly[i];
      m_wready[i]        = m_wvalid[i] && wc[i] >= dly[i];
      m_arready[i]       = m_arvalid[i] && arc[i] >= dly[i];
      m_bresp[2*i +: 2]  = bresp_cfg[i];
      m_rresp[2*i +: 2]  = rresp_cfg[i];
      m_rdata[32*i +: 32] = rd_cfg[i];
    end
  end
  assign m_bvalid = bv;
  assign m_rvalid = rv;
  // Stub slaves: B fires once both AW and W have landed (unless held), R fires the cycle after AR.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_got <= '0;
      w_got  <= '0;
      bv     <= '0;
      rv     <= '0;
      arcyc  <= 0;
      for (int i = 0; i < N; i++) begin
        awc[i] <= 0; wc[i] <= 0; arc[i] <= 0; aw_n[i] <= 0; w_n[i] <= 0; vcyc[i] <= 0;
        l_awaddr[i] <= '0; l_araddr[i] <= '0; l_awprot[i] <= '0; l_wdata[i] <= '0; l_wstrb[i] <= '0;
      end
    end else begin
      arcyc <= arcyc + ((|m_arvalid) ? 1 : 0);
      for (int i = 0; i < N; i++) begin
        awc[i] <= (m_awvalid[i] && !m_awready[i]) ? awc[i] + 1 : 0;
        wc[i]  <= (m_wvalid[i] && !m_wready[i]) ? wc[i] + 1 : 0;
        arc[i] <= (m_arvalid[i] && !m_arready[i]) ? arc[i] + 1 : 0;
        if (m_awvalid[i] || m_wvalid[i] || m_arvalid[i]) vcyc[i] <= vcyc[i] + 1;
        if (m_awvalid[i] && m_awready[i]) begin
          aw_got[i] <= 1'b1; aw_n[i] <= aw_n[i] + 1; l_awaddr[i] <= m_awaddr; l_awprot[i] <= m_awprot;
        end
        if (m_wvalid[i] && m_wready[i]) begin
          w_got[i] <= 1'b1; w_n[i] <= w_n[i] + 1; l_wdata[i] <= m_wdata; l_wstrb[i] <= m_wstrb;
        end
        if (bv[i] && m_bready[i]) bv[i] <= 1'b0;
        if (!bv[i] && !bhold[i] && (aw_got[i] || (m_awvalid[i] && m_awready[i])) &&
            (w_got[i] || (m_wvalid[i] && m_wready[i]))) begin
          bv[i] <= 1'b1; aw_got[i] <= 1'b0; w_got[i] <= 1'b0;
        end
        if (rv[i] && m_rready[i]) rv[i] <= 1'b0;
        if (m_arvalid[i] && m_arready[i]) begin
          rv[i] <= 1'b1; l_araddr[i] <= m_araddr;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_b(output logic [1:0] resp);
    for (int k = 0; k < 40 && !s_bvalid; k++) tick();
    chk("bvalid_seen", s_bvalid, 1);
    resp = s_bresp;
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
  endtask
  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, output logic [1:0] resp);
    logic an, wn;
    s_awaddr = a; s_awprot = p; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int k = 0; k < 40 && (s_awvalid || s_wvalid); k++) begin
      an = s_awready; wn = s_wready;
      tick();
      if (an) s_awvalid = 1'b0;
      if (wn) s_wvalid = 1'b0;
    end
    chk("aw_w_accepted", {s_awvalid, s_wvalid}, 0);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    wait_b(resp);
  endtask
  task automatic send_ar(input logic [15:0] a, input logic [2:0] p);
    logic an;
    s_araddr = a; s_arprot = p; s_arvalid = 1'b1;
    for (int k = 0; k < 40 && s_arvalid; k++) begin
      an = s_arready;
      tick();
      if (an) s_arvalid = 1'b0;
    end
    chk("ar_accepted", s_arvalid, 0);
    s_arvalid = 1'b0;
  endtask
  task automatic wait_r();
    for (int k = 0; k < 40 && !s_rvalid; k++) tick();
    chk("rvalid_seen", s_rvalid, 1);
  endtask
  task automatic take_r(output logic [31:0] d, output logic [1:0] r);
    d = s_rdata; r = s_rresp;
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [1:0] resp, rr;
    logic [31:0] rd;
    int ar0;
    s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
    s_awaddr = 0; s_araddr = 0; s_awprot = 0; s_arprot = 0; s_wdata = 0; s_wstrb = 0;
    bhold = '0;
    for (int i = 0; i < N; i++) begin
      dly[i] = 0; bresp_cfg[i] = 2'b00; rresp_cfg[i] = 2'b00; rd_cfg[i] = 32'h1000_0000 + i;
    end
    rd_cfg[2] = 32'hDEADBEEF;
    rd_cfg[3] = 32'h3C3C5A5A;
    rresp_cfg[3] = 2'b10;
    #3;
    chk("rst_awready", s_awready, 0);
    chk("rst_arready", s_arready, 0);
    chk("rst_bvalid", s_bvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("awready_before_edge", s_awready, 0);
    tick();
    chk("awready_up", s_awready, 1);
    chk("wready_up", s_wready, 1);
    chk("arready_up", s_arready, 1);
    // 1: write to slave 1 with cycle-exact latency
    s_awaddr = 16'h0048; s_awprot = 3'b000; s_wdata = 32'hCA55E77E; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    chk("t1_m_awvalid", m_awvalid, 4'b0010);
    chk("t1_m_wvalid", m_wvalid, 4'b0010);
    chk("t1_m_awaddr", m_awaddr, 6'h08);
    chk("t1_m_wdata", m_wdata, 32'hCA55E77E);
    chk("t1_m_wstrb", m_wstrb, 4'hF);
    chk("t1_awready_busy", s_awready, 0);
    tick();
    chk("t1_m_awvalid_drop", m_awvalid, 0);
    chk("t1_m_bready", m_bready, 4'b0010);
    chk("t1_bvalid_early", s_bvalid, 0);
    tick();
    chk("t1_bvalid", s_bvalid, 1);
    chk("t1_bresp", s_bresp, 2'b00);
    s_bready = 1; tick(); s_bready = 0;
    chk("t1_bvalid_clr", s_bvalid, 0);
    chk("t1_s0_quiet", vcyc[0], 0);
    chk("t1_s2_quiet", vcyc[2], 0);
    chk("t1_s3_quiet", vcyc[3], 0);
    chk("t1_s1_awn", aw_n[1], 1);
    chk("t1_s1_wdata", l_wdata[1], 32'hCA55E77E);
    // 2: read miss, upper address bits set
    ar0 = arcyc;
    s_araddr = 16'h0100; s_arvalid = 1;
    tick();
    s_arvalid = 0;
    chk("t2_rvalid_early", s_rvalid, 0);
    tick();
    chk("t2_rvalid", s_rvalid, 1);
    chk("t2_rresp", s_rresp, 2'b11);
    chk("t2_rdata", s_rdata, 0);
    take_r(rd, rr);
    chk("t2_no_arvalid", arcyc - ar0, 0);
    do_write(16'h0100, 32'h1, 4'h1, 3'b000, resp);
    chk("miss_bresp", resp, 2'b11);
    // 3: AW first, W three cycles later, slave 2 with two-cycle ready delay
    dly[2] = 2;
    s_awaddr = 16'h0080; s_awprot = 3'b000; s_awvalid = 1;
    tick();
    s_awvalid = 0;
    chk("t3_awready_c1", s_awready, 0);
    chk("t3_wready_c1", s_wready, 1);
    tick();
    chk("t3_awready_c2", s_awready, 0);
    tick();
    chk("t3_awready_c3", s_awready, 0);
    s_wdata = 32'h12345678; s_wstrb = 4'hA; s_wvalid = 1;
    tick();
    s_wvalid = 0;
    chk("t3_m_awvalid", m_awvalid, 4'b0100);
    wait_b(resp);
    chk("t3_bresp", resp, 2'b00);
    chk("t3_awn", aw_n[2], 1);
    chk("t3_wn", w_n[2], 1);
    chk("t3_wdata", l_wdata[2], 32'h12345678);
    chk("t3_awaddr", l_awaddr[2], 6'h00);
    // 4: concurrent write to slave 0 (strb 0, prot passthrough) and read from slave 2
    fork
      do_write(16'h0014, 32'hA5A50F0F, 4'h0, 3'b101, resp);
      begin
        send_ar(16'h0088, 3'b010);
        wait_r();
        take_r(rd, rr);
      end
    join
    chk("t4_bresp", resp, 2'b00);
    chk("t4_rdata", rd, 32'hDEADBEEF);
    chk("t4_rresp", rr, 2'b00);
    chk("t4_awaddr", l_awaddr[0], 6'h14);
    chk("t4_wstrb0", l_wstrb[0], 4'h0);
    chk("t4_awprot", l_awprot[0], 3'b101);
    chk("t4_wdata", l_wdata[0], 32'hA5A50F0F);
    chk("t4_araddr", l_araddr[2], 6'h08);
    // 5: SLVERR read from slave 3 at the top of the mapped space, response back-pressured
    send_ar(16'h00FC, 3'b000);
    wait_r();
    for (int c = 0; c < 5; c++) begin
      chk("t5_rvalid_hold", s_rvalid, 1);
      chk("t5_rdata_hold", s_rdata, 32'h3C3C5A5A);
      chk("t5_rresp_hold", s_rresp, 2'b10);
      chk("t5_arready_low", s_arready, 0);
      tick();
    end
    take_r(rd, rr);
    chk("t5_rresp", rr, 2'b10);
    chk("t5_araddr", l_araddr[3], 6'h3C);
    chk("t5_arready_back", s_arready, 1);
    // 6: reset while waiting on a held B response
    bhold[1] = 1'b1;
    s_awaddr = 16'h0040; s_wdata = 32'h0BAD0BAD; s_wstrb = 4'hF;
    s_awvalid = 1; s_wvalid = 1;
    tick();
    s_awvalid = 0; s_wvalid = 0;
    tick();
    tick();
    chk("t6_in_wait", m_bready, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_bready", m_bready, 0);
    chk("t6_rst_awvalid", m_awvalid, 0);
    chk("t6_rst_wvalid", m_wvalid, 0);
    chk("t6_rst_bvalid", s_bvalid, 0);
    chk("t6_rst_awready", s_awready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    bhold = '0;
    tick();
    chk("t6_awready_after", s_awready, 1);
    chk("t6_no_bvalid", s_bvalid, 0);
    do_write(16'h0004, 32'h600DF00D, 4'h3, 3'b000, resp);
    chk("t6_bresp", resp, 2'b00);
    chk("t6_awaddr", l_awaddr[0], 6'h04);
    chk("t6_wdata", l_wdata[0], 32'h600DF00D);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
